// File: rtl/prg_loader_if.sv
// prg_loader_if: groups the hps_io ioctl byte stream and the pet2001hw DMA write port.
//   ioctl_download/index/wr/addr/dout : byte stream from hps_io (master drives)
//   ioctl_wait                         : stall request back to hps_io (slave drives)
//   dma_busy                           : downstream cannot take a write (master drives)
//   dma_addr/dma_dout/dma_we           : RAM write port (slave drives)
// The loader uses the slave modport; the surrounding system uses master.
`timescale 1ns/1ps
interface prg_loader_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        dma_busy;
    logic [15:0] dma_addr;
    logic [7:0]  dma_dout;
    logic        dma_we;

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, dma_busy,
        output ioctl_wait, dma_addr, dma_dout, dma_we
    );

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, dma_busy,
        input  ioctl_wait, dma_addr, dma_dout, dma_we
    );
endinterface

// File: rtl/prg_loader.sv
// prg_loader: turns a PRG file streamed over ioctl into DMA writes into PET RAM, then writes
// the BASIC end-of-program pointers (VARTAB/ARYTAB/STREND) so RUN and LIST work at once.
// Ports:
//   clk, reset_n          : system clock, synchronous active-low reset
//   bus (slave)           : ioctl byte stream in, ioctl_wait out, DMA write port out
//   busy                  : download start until the pointer phase completes
//   load_start, load_end  : parsed load address, first address after the last written byte
//   err_short, err_trunc  : sticky: file under 3 bytes / payload truncated at MEM_LIMIT
// Optional: define PRG_AUTORUN_EN to add a KBD phase that types "RUN<CR>" into the keyboard
// buffer after the pointers are written.
`timescale 1ns/1ps
module prg_loader #(
    parameter logic [7:0]  PRG_INDEX = 8'h41,
    parameter logic [15:0] MEM_LIMIT = 16'h8000,
    parameter logic [15:0] PTR_BASE  = 16'h002A,
    parameter int unsigned PTR_COUNT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    prg_loader_if.slave bus,
    output logic        busy,
    output logic [15:0] load_start,
    output logic [15:0] load_end,
    output logic        err_short,
    output logic        err_trunc
);

`ifdef PRG_AUTORUN_EN
    typedef enum logic [2:0] {StIdle, StHdr, StData, StPtr, StDone, StKbd} state_e;
    localparam logic [7:0] KbdLast = 8'd4;
`else
    typedef enum logic [2:0] {StIdle, StHdr, StData, StPtr, StDone} state_e;
`endif

    localparam logic [7:0] PtrLast = 8'(2 * PTR_COUNT - 1);

    state_e      state_q, state_d;
    logic        sel, sel_q, rise;
    logic        slot_full_q, slot_full_d;
    logic [15:0] slot_addr_q, slot_addr_d;
    logic [7:0]  slot_data_q, slot_data_d;
    logic [15:0] cur_addr_q, cur_addr_d;
    logic [15:0] load_start_q, load_start_d;
    logic [15:0] load_end_q, load_end_d;
    logic        err_short_q, err_short_d;
    logic        err_trunc_q, err_trunc_d;
    logic        busy_q, busy_d;
    logic        seen_q, seen_d;  // at least one payload byte accepted
    logic [7:0]  idx_q, idx_d;    // write index inside PTR / KBD
    logic        gap_q, gap_d;    // forced idle cycle after each PTR / KBD write
    logic        we_c;

    assign sel  = bus.ioctl_download && (bus.ioctl_index == PRG_INDEX);
    assign rise = sel && !sel_q;

    // DMA port: the pending slot has priority; it is only ever full in DATA.
    always_comb begin
        we_c         = 1'b0;
        bus.dma_addr = 16'h0000;
        bus.dma_dout = 8'h00;
        if (slot_full_q) begin
            bus.dma_addr = slot_addr_q;
            bus.dma_dout = slot_data_q;
            we_c         = !bus.dma_busy;
        end else if (state_q == StPtr && !gap_q) begin
            bus.dma_addr = PTR_BASE + {8'h00, idx_q};
            bus.dma_dout = idx_q[0] ? load_end_q[15:8] : load_end_q[7:0];
            we_c         = !bus.dma_busy && !rise;
        end
`ifdef PRG_AUTORUN_EN
        else if (state_q == StKbd && !gap_q) begin
            unique case (idx_q)
                8'd0:    begin bus.dma_addr = 16'h026F; bus.dma_dout = 8'h52; end
                8'd1:    begin bus.dma_addr = 16'h0270; bus.dma_dout = 8'h55; end
                8'd2:    begin bus.dma_addr = 16'h0271; bus.dma_dout = 8'h4E; end
                8'd3:    begin bus.dma_addr = 16'h0272; bus.dma_dout = 8'h0D; end
                default: begin bus.dma_addr = 16'h009E; bus.dma_dout = 8'h04; end
            endcase
            we_c = !bus.dma_busy && !rise;
        end
`endif
        // A reset cycle must never leak a write.
        bus.dma_we = we_c && reset_n;
    end

    assign bus.ioctl_wait = slot_full_q;
    assign busy           = busy_q;
    assign load_start     = load_start_q;
    assign load_end       = load_end_q;
    assign err_short      = err_short_q;
    assign err_trunc      = err_trunc_q;

    always_comb begin
        state_d      = state_q;
        slot_full_d  = slot_full_q && !we_c;
        slot_addr_d  = slot_addr_q;
        slot_data_d  = slot_data_q;
        cur_addr_d   = cur_addr_q;
        load_start_d = load_start_q;
        load_end_d   = load_end_q;
        err_short_d  = err_short_q;
        err_trunc_d  = err_trunc_q;
        busy_d       = busy_q;
        seen_d       = seen_q;
        idx_d        = idx_q;
        gap_d        = gap_q;

        if (rise) begin
            // New PRG download; also aborts a pointer/keyboard phase in progress.
            state_d      = StHdr;
            busy_d       = 1'b1;
            slot_full_d  = 1'b0;
            load_start_d = 16'h0000;
            load_end_d   = 16'h0000;
            err_short_d  = 1'b0;
            err_trunc_d  = 1'b0;
            seen_d       = 1'b0;
            idx_d        = 8'd0;
            gap_d        = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StHdr: begin
                    if (!sel) begin
                        err_short_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = StDone;
                    end else if (bus.ioctl_wr) begin
                        if (bus.ioctl_addr == 25'd0) begin
                            load_start_d[7:0] = bus.ioctl_dout;
                        end else if (bus.ioctl_addr == 25'd1) begin
                            load_start_d[15:8] = bus.ioctl_dout;
                            cur_addr_d         = {bus.ioctl_dout, load_start_q[7:0]};
                            load_end_d         = {bus.ioctl_dout, load_start_q[7:0]};
                            state_d            = StData;
                        end
                    end
                end
                StData: begin
                    if (!sel) begin
                        if (!seen_q) begin
                            err_short_d = 1'b1;
                            busy_d      = 1'b0;
                            state_d     = StDone;
                        end else if (!slot_full_q) begin
                            idx_d   = 8'd0;
                            gap_d   = 1'b0;
                            state_d = StPtr;
                        end
                    end else if (bus.ioctl_wr && (bus.ioctl_addr[24:1] != 24'd0)) begin
                        // cur_addr stops at MEM_LIMIT, so it can never wrap.
                        if (cur_addr_q < MEM_LIMIT) begin
                            slot_full_d = 1'b1;
                            slot_addr_d = cur_addr_q;
                            slot_data_d = bus.ioctl_dout;
                            cur_addr_d  = cur_addr_q + 16'd1;
                            load_end_d  = cur_addr_q + 16'd1;
                            seen_d      = 1'b1;
                        end else begin
                            err_trunc_d = 1'b1;
                        end
                    end
                end
                StPtr: begin
                    if (gap_q) begin
                        gap_d = 1'b0;
                    end else if (we_c) begin
                        gap_d = 1'b1;
                        if (idx_q == PtrLast) begin
                            idx_d = 8'd0;
`ifdef PRG_AUTORUN_EN
                            state_d = StKbd;
`else
                            busy_d  = 1'b0;
                            state_d = StDone;
`endif
                        end else begin
                            idx_d = idx_q + 8'd1;
                        end
                    end
                end
`ifdef PRG_AUTORUN_EN
                StKbd: begin
                    if (gap_q) begin
                        gap_d = 1'b0;
                    end else if (we_c) begin
                        gap_d = 1'b1;
                        if (idx_q == KbdLast) begin
                            busy_d  = 1'b0;
                            state_d = StDone;
                        end else begin
                            idx_d = idx_q + 8'd1;
                        end
                    end
                end
`endif
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            sel_q        <= 1'b0;
            slot_full_q  <= 1'b0;
            slot_addr_q  <= 16'h0000;
            slot_data_q  <= 8'h00;
            cur_addr_q   <= 16'h0000;
            load_start_q <= 16'h0000;
            load_end_q   <= 16'h0000;
            err_short_q  <= 1'b0;
            err_trunc_q  <= 1'b0;
            busy_q       <= 1'b0;
            seen_q       <= 1'b0;
            idx_q        <= 8'd0;
            gap_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel;
            slot_full_q  <= slot_full_d;
            slot_addr_q  <= slot_addr_d;
            slot_data_q  <= slot_data_d;
            cur_addr_q   <= cur_addr_d;
            load_start_q <= load_start_d;
            load_end_q   <= load_end_d;
            err_short_q  <= err_short_d;
            err_trunc_q  <= err_trunc_d;
            busy_q       <= busy_d;
            seen_q       <= seen_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
        end
    end

endmodule

// File: tb/tb_prg_loader.sv
// tb_prg_loader: directed bench for prg_loader. DMA writes are logged on the falling edge and
// compared against hand-computed expected write lists after each download.
`timescale 1ns/1ps
module tb_prg_loader;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        busy;
    logic [15:0] load_start, load_end;
    logic        err_short, err_trunc;

    int checks = 0;
    int errors = 0;

    logic [23:0] log_q[$];
    logic [23:0] exp_q[$];

    prg_loader_if bus ();

    prg_loader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .busy       (busy),
        .load_start (load_start),
        .load_end   (load_end),
        .err_short  (err_short),
        .err_trunc  (err_trunc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.dma_we) log_q.push_back({bus.dma_addr, bus.dma_dout});
    end

    // A byte strobe while the loader is stalling would overwrite the pending byte.
    always @(negedge clk) begin
        if (reset_n && bus.ioctl_wr) begin
            checks++;
            assert (bus.ioctl_wait === 1'b0) else begin
                errors++;
                $error("FAIL wr_during_wait: ioctl_wait=%b required 0", bus.ioctl_wait);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: timed out", tag);
    endtask

    task automatic send(input logic [24:0] a, input logic [7:0] d);
        int t = 0;
        while (bus.ioctl_wait && t < 50) begin
            step();
            t++;
        end
        if (t >= 50) timeout("send_wait");
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        bus.ioctl_wr   = 1'b1;
        step();
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
        step();
    endtask

    task automatic end_dl();
        int t = 0;
        bus.ioctl_download = 1'b0;
        step();
        while (busy && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) timeout("end_dl_busy");
        step();
        step();
    endtask

    task automatic push_ptrs(input logic [15:0] e);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({16'h002A + 16'(2 * k), e[7:0]});
            exp_q.push_back({16'h002B + 16'(2 * k), e[15:8]});
        end
`ifdef PRG_AUTORUN_EN
        exp_q.push_back({16'h026F, 8'h52});
        exp_q.push_back({16'h0270, 8'h55});
        exp_q.push_back({16'h0271, 8'h4E});
        exp_q.push_back({16'h0272, 8'h0D});
        exp_q.push_back({16'h009E, 8'h04});
`endif
    endtask

    task automatic check_log(input string tag);
        int n;
        chk({tag, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_wr%0d", tag, i), {8'h00, log_q[i]}, {8'h00, exp_q[i]});
        end
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_lstart"}, {16'd0, load_start}, 32'd0);
        chk({tag, "_lend"}, {16'd0, load_end}, 32'd0);
        chk({tag, "_eshort"}, {31'd0, err_short}, 32'd0);
        chk({tag, "_etrunc"}, {31'd0, err_trunc}, 32'd0);
        chk({tag, "_wait"}, {31'd0, bus.ioctl_wait}, 32'd0);
        chk({tag, "_we"}, {31'd0, bus.dma_we}, 32'd0);
        chk({tag, "_daddr"}, {16'd0, bus.dma_addr}, 32'd0);
        chk({tag, "_ddout"}, {24'd0, bus.dma_dout}, 32'd0);
    endtask

    initial begin
        int t;
        reset_n            = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'h00;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = 25'd0;
        bus.ioctl_dout     = 8'h00;
        bus.dma_busy       = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");
        reset_n = 1'b1;
        step();

        // Basic file 01 04 0A 0B 0C; each payload write one cycle after its strobe.
        start_dl(8'h41);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        send(25'd0, 8'h01);
        send(25'd1, 8'h04);
        send(25'd2, 8'h0A);
        chk("t1_lat0", {31'd0, bus.dma_we}, 32'd1);
        send(25'd3, 8'h0B);
        chk("t1_lat1", {31'd0, bus.dma_we}, 32'd1);
        send(25'd4, 8'h0C);
        chk("t1_lat2", {31'd0, bus.dma_we}, 32'd1);
        end_dl();
        exp_q.push_back({16'h0401, 8'h0A});
        exp_q.push_back({16'h0402, 8'h0B});
        exp_q.push_back({16'h0403, 8'h0C});
        push_ptrs(16'h0404);
        check_log("t1");
        chk("t1_lstart", {16'd0, load_start}, 32'h0401);
        chk("t1_lend", {16'd0, load_end}, 32'h0404);
        chk("t1_eshort", {31'd0, err_short}, 32'd0);
        chk("t1_etrunc", {31'd0, err_trunc}, 32'd0);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);

        // Load at $7FFE with 4 payload bytes: truncated at MEM_LIMIT.
        start_dl(8'h41);
        send(25'd0, 8'hFE);
        send(25'd1, 8'h7F);
        send(25'd2, 8'h11);
        send(25'd3, 8'h22);
        send(25'd4, 8'h33);
        send(25'd5, 8'h44);
        end_dl();
        exp_q.push_back({16'h7FFE, 8'h11});
        exp_q.push_back({16'h7FFF, 8'h22});
        push_ptrs(16'h8000);
        check_log("t2");
        chk("t2_lstart", {16'd0, load_start}, 32'h7FFE);
        chk("t2_lend", {16'd0, load_end}, 32'h8000);
        chk("t2_etrunc", {31'd0, err_trunc}, 32'd1);
        chk("t2_eshort", {31'd0, err_short}, 32'd0);

        // dma_busy held after the first payload byte: stall, then exactly one write.
        start_dl(8'h41);
        send(25'd0, 8'h00);
        send(25'd1, 8'h10);
        bus.dma_busy   = 1'b1;
        bus.ioctl_addr = 25'd2;
        bus.ioctl_dout = 8'hA1;
        bus.ioctl_wr   = 1'b1;
        step();
        bus.ioctl_wr   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_wait%0d", i), {31'd0, bus.ioctl_wait}, 32'd1);
            chk($sformatf("t3_nowe%0d", i), {31'd0, bus.dma_we}, 32'd0);
            step();
        end
        bus.dma_busy = 1'b0;
        #1;
        chk("t3_we", {31'd0, bus.dma_we}, 32'd1);
        chk("t3_addr", {16'd0, bus.dma_addr}, 32'h1000);
        chk("t3_dout", {24'd0, bus.dma_dout}, 32'h00A1);
        step();
        chk("t3_wait_clr", {31'd0, bus.ioctl_wait}, 32'd0);
        send(25'd3, 8'hA2);
        end_dl();
        exp_q.push_back({16'h1000, 8'hA1});
        exp_q.push_back({16'h1001, 8'hA2});
        push_ptrs(16'h1002);
        check_log("t3");

        // Short files: 1 byte, then 2 bytes.
        start_dl(8'h41);
        send(25'd0, 8'h01);
        end_dl();
        chk("t4a_eshort", {31'd0, err_short}, 32'd1);
        check_log("t4a");
        start_dl(8'h41);
        send(25'd0, 8'h01);
        send(25'd1, 8'h04);
        end_dl();
        chk("t4b_eshort", {31'd0, err_short}, 32'd1);
        chk("t4b_etrunc", {31'd0, err_trunc}, 32'd0);
        check_log("t4b");

        // Restart during PTR after the second pointer write.
        start_dl(8'h41);
        send(25'd0, 8'h00);
        send(25'd1, 8'h05);
        send(25'd2, 8'h99);
        bus.ioctl_download = 1'b0;
        t = 0;
        while (log_q.size() < 3 && t < 100) begin
            step();
            t++;
        end
        if (t >= 100) timeout("t5_ptr_wait");
        start_dl(8'h41);
        chk("t5_busy", {31'd0, busy}, 32'd1);
        send(25'd0, 8'h00);
        send(25'd1, 8'h06);
        send(25'd2, 8'h77);
        send(25'd3, 8'h88);
        end_dl();
        exp_q.push_back({16'h0500, 8'h99});
        exp_q.push_back({16'h002A, 8'h01});
        exp_q.push_back({16'h002B, 8'h05});
        exp_q.push_back({16'h0600, 8'h77});
        exp_q.push_back({16'h0601, 8'h88});
        push_ptrs(16'h0602);
        check_log("t5");
        chk("t5_lstart", {16'd0, load_start}, 32'h0600);
        chk("t5_lend", {16'd0, load_end}, 32'h0602);

        // Foreign index: ignored entirely.
        start_dl(8'h00);
        for (int i = 0; i < 100; i++) begin
            send(25'(i), 8'(i));
            chk($sformatf("t6_wait%0d", i), {31'd0, bus.ioctl_wait}, 32'd0);
            chk($sformatf("t6_busy%0d", i), {31'd0, busy}, 32'd0);
        end
        end_dl();
        check_log("t6");

        // Reset mid-DATA clears everything on the next cycle.
        start_dl(8'h41);
        send(25'd0, 8'h00);
        send(25'd1, 8'h07);
        send(25'd2, 8'hAA);
        send(25'd3, 8'hBB);
        reset_n            = 1'b0;
        bus.ioctl_download = 1'b0;
        step();
        chk_all_zero("t7");
        reset_n = 1'b1;
        repeat (20) step();
        exp_q.push_back({16'h0700, 8'hAA});
        check_log("t7");
        chk("t7_busy_after", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
